stepper_move_ctrl: RTL and testbench
====================================

STEPPER_MOVE_CTRL -- requirements
Module: stepper_move_ctrl

Interface
REQ-001 Parameter POS_W, default 16, width of step count and position.
REQ-002 Parameter DIV_W, default 21, width of step-period divider values.
REQ-003 Parameter MAX_DIV, default 2000000, step period in clk cycles at standstill (start/stop speed).
REQ-004 Parameter MIN_DIV, default 250000, step period in clk cycles at cruise speed. Legal only if 2 <= MIN_DIV <= MAX_DIV.
REQ-005 Parameter ACC_DEC, default 250000, divider change per step while ramping.
REQ-006 clk  in  1  single clock; all logic is synchronous to its rising edge.
REQ-007 rst  in  1  reset; synchronous and active-high.
REQ-008 cmd_valid  in  1  move request.
REQ-009 cmd_ready  out  1  high when a move can be accepted; equals ~busy.
REQ-010 cmd_steps  in  POS_W  number of step ticks to issue; unsigned.
REQ-011 cmd_dir  in  1  1 = forward (index increments), 0 = reverse.
REQ-012 cmd_half  in  1  1 = half-step mode, 0 = full-step (two-phase-on) mode.
REQ-013 abort  in  1  request a controlled ramp-down stop.
REQ-014 hold_en  in  1  1 = keep the last coil pattern energised while idle.
REQ-015 pulses_out  out  4  coil drive pattern.
REQ-016 busy  out  1  move in progress.
REQ-017 done  out  1  one-cycle pulse at the end of each move.
REQ-018 position  out  POS_W  signed position in half-step units; wraps modulo 2^POS_W.

Function
REQ-019 The FSM SHALL have states IDLE, ACCEL, CRUISE and DECEL.
REQ-020 A move is accepted on cmd_valid && cmd_ready. cmd_steps, cmd_dir and cmd_half are latched on that edge. busy rises the next cycle. cmd_valid while busy is ignored.
REQ-021 On accept: cur_div = MAX_DIV, ramp_cnt = 0, period counter = 0, remaining = cmd_steps, next state ACCEL.
REQ-022 A step tick fires when the period counter reaches cur_div-1; the counter then returns to 0. The first tick therefore occurs MAX_DIV cycles after acceptance.
REQ-023 On each tick, phase index, position, remaining, cur_div and ramp_cnt all update on the same edge.
REQ-024 ACCEL tick: cur_div = max(cur_div-ACC_DEC, MIN_DIV) and ramp_cnt increments. On reaching MIN_DIV, go to CRUISE.
REQ-025 ACCEL/CRUISE tick: if remaining-after-tick <= ramp_cnt-after-tick, go to DECEL.
REQ-026 DECEL tick: cur_div = min(cur_div+ACC_DEC, MAX_DIV) and ramp_cnt decrements, saturating at 0.
REQ-027 When remaining reaches 0, go to IDLE. done pulses and busy falls in the cycle after the last tick.
REQ-028 cmd_steps = 0: no tick, no pattern or position change; done pulses and busy falls one cycle after busy rises.
REQ-029 abort in ACCEL/CRUISE: remaining = min(remaining, ramp_cnt) and go to DECEL. If the result is 0, finish as in REQ-027.
REQ-030 abort in IDLE or DECEL SHALL have no effect. Simultaneous abort and tick: the tick update applies first, then abort.
REQ-031 The 3-bit phase index selects, for indices 0..7: 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001.
REQ-032 Half mode: each tick moves the index ±1 mod 8.
REQ-033 Full mode: each tick moves the index ±2 mod 8. If the index is even, the first tick of the move moves ±1 instead, to align onto a two-phase-on entry.
REQ-034 position changes by the signed index delta applied (±1 or ±2).
REQ-035 pulses_out = table[index] while busy, or while idle with hold_en = 1. Otherwise pulses_out = 0000.

Reset
REQ-036 rst SHALL return the block to IDLE with: index 0, position 0, remaining 0, ramp_cnt 0, cur_div MAX_DIV, busy 0, done 0, pulses_out 0000, cmd_ready 1.
REQ-037 rst mid-move SHALL abandon the move immediately without a done pulse. Reset has priority over every other input.

Structure
REQ-038 The phase table constant and the state enum SHALL live in the shared package stepper_pkg.
REQ-039 Phase decoding SHALL be the sub-module stepper_phase_seq, with inputs clk, rst, tick, dir, half, hold_en, busy and outputs pulses_out, delta.

Verification
All scenarios use MAX_DIV = 8, MIN_DIV = 4, ACC_DEC = 2.
REQ-040 Reset, hold_en = 0 -> pulses_out 0000, busy 0, cmd_ready 1, position 0, done 0.
REQ-041 Forward, half mode, 10 steps -> tick intervals 8,6,4,4,4,4,4,4,6,8 (52 cycles total); position 10; index 2; single done pulse.
REQ-042 cmd_steps = 0 -> done one cycle after busy rises; pulses_out and position unchanged.
REQ-043 Reverse, full mode, 3 steps from index 0 -> patterns 1001, 0011, 0110; position -5.
REQ-044 100-step move, abort asserted during CRUISE -> exactly 2 further ticks at intervals 6 and 8, then done; position = ticks issued.
REQ-045 cmd_valid pulsed while busy -> ignored, original move completes unchanged; rst asserted mid-move -> REQ-036 values next cycle, no done pulse.

Source files
------------

// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper move controller: the move FSM states and
// the eight-entry coil drive table indexed by the 3-bit phase index.
package stepper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEL  = 2'd1,
        ST_CRUISE = 2'd2,
        ST_DECEL  = 2'd3
    } state_t;

    // Even indices energise one coil, odd indices two (two-phase-on).
    localparam logic [7:0][3:0] PHASE_TABLE = {
        4'b1001, 4'b0001, 4'b0011, 4'b0010,
        4'b0110, 4'b0100, 4'b1100, 4'b1000
    };

endpackage

// File: rtl/stepper_phase_seq.sv
// Phase index sequencer: advances the coil table index on each step tick and
// reports the signed index delta so the top can keep position in step.
module stepper_phase_seq
    import stepper_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              dir,
    input  logic              half,
    input  logic              hold_en,
    input  logic              busy,
    output logic [3:0]        pulses_out,
    output logic signed [2:0] delta
);

    logic [2:0] idx_q;
    logic       first_q;
    logic [2:0] mag;

    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        mag = 3'd2;
        // In full-step mode an even (single-coil) index is pulled onto a two-coil entry first.
        if (half || (first_q && !idx_q[0])) begin
            mag = 3'd1;
        end
        delta = dir ? mag : 3'd0 - mag;
        pulses_out = (busy || hold_en) ? PHASE_TABLE[idx_q] : 4'b0000;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= 3'd0;
            first_q <= 1'b1;
        end else begin
            if (!busy) begin
                first_q <= 1'b1;
            end else if (tick) begin
                first_q <= 1'b0;
            end
            if (tick) begin
                idx_q <= idx_q + unsigned'(delta);
            end
        end
    end

endmodule

// File: rtl/stepper_move_ctrl.sv
// Trapezoidal-ramp stepper move controller: accepts a step count, ramps the
// step period from MAX_DIV down to MIN_DIV and back, and supports abort.
module stepper_move_ctrl
    import stepper_pkg::*;
#(
    parameter int POS_W   = 16,
    parameter int DIV_W   = 21,
    parameter int MAX_DIV = 2000000,
    parameter int MIN_DIV = 250000,
    parameter int ACC_DEC = 250000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [POS_W-1:0] cmd_steps,
    input  logic             cmd_dir,
    input  logic             cmd_half,
    input  logic             abort,
    input  logic             hold_en,
    output logic [3:0]       pulses_out,
    output logic             busy,
    output logic             done,
    output logic [POS_W-1:0] position
);

    localparam logic [DIV_W-1:0] MAX_C = DIV_W'(MAX_DIV);
    localparam logic [DIV_W-1:0] MIN_C = DIV_W'(MIN_DIV);
    localparam logic [DIV_W-1:0] ACC_C = DIV_W'(ACC_DEC);

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  cur_div_q, cur_div_d;
    logic [POS_W-1:0]  ramp_q, ramp_d;
    logic [POS_W-1:0]  rem_q, rem_d;
    logic [POS_W-1:0]  position_q, position_d;
    logic              dir_q, dir_d;
    logic              half_q, half_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tick;
    logic              enter_decel;
    logic signed [2:0] delta;

    function automatic logic [DIV_W-1:0] accel_div(input logic [DIV_W-1:0] d);
        return (d - MIN_C <= ACC_C) ? MIN_C : d - ACC_C;
    endfunction

    function automatic logic [DIV_W-1:0] decel_div(input logic [DIV_W-1:0] d);
        return (MAX_C - d <= ACC_C) ? MAX_C : d + ACC_C;
    endfunction

    function automatic logic [POS_W-1:0] ramp_dec(input logic [POS_W-1:0] r);
        return (r == '0) ? '0 : r - POS_W'(1);
    endfunction

    assign tick = busy_q && (rem_q != '0) && (cnt_q == cur_div_q - DIV_W'(1));

    stepper_phase_seq u_phase_seq (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .dir        (dir_q),
        .half       (half_q),
        .hold_en    (hold_en),
        .busy       (busy_q),
        .pulses_out (pulses_out),
        .delta      (delta)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cur_div_d   = cur_div_q;
        ramp_d      = ramp_q;
        rem_d       = rem_q;
        position_d  = position_q;
        dir_d       = dir_q;
        half_d      = half_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        enter_decel = 1'b0;

        if (state_q == ST_IDLE) begin
            if (cmd_valid) begin
                state_d   = ST_ACCEL;
                cnt_d     = '0;
                cur_div_d = MAX_C;
                ramp_d    = '0;
                rem_d     = cmd_steps;
                dir_d     = cmd_dir;
                half_d    = cmd_half;
                busy_d    = 1'b1;
            end
        end else begin
            if (tick) begin
                cnt_d      = '0;
                rem_d      = rem_q - POS_W'(1);
                position_d = position_q + {{(POS_W-3){delta[2]}}, delta};
                if (state_q == ST_ACCEL) begin
                    cur_div_d = accel_div(cur_div_q);
                    ramp_d    = ramp_q + POS_W'(1);
                    if (cur_div_d == MIN_C) begin
                        state_d = ST_CRUISE;
                    end
                end else if (state_q == ST_DECEL) begin
                    cur_div_d = decel_div(cur_div_q);
                    ramp_d    = ramp_dec(ramp_q);
                end
                if (state_q != ST_DECEL && rem_d <= ramp_d) begin
                    enter_decel = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end

            // Abort sees the post-tick counters; a tick that already chose DECEL wins.
            if (abort && state_q != ST_DECEL && !enter_decel) begin
                rem_d       = (rem_d < ramp_d) ? rem_d : ramp_d;
                enter_decel = 1'b1;
            end

            // Entering DECEL lengthens the period immediately so the ramp-down mirrors the ramp-up.
            if (enter_decel) begin
                state_d   = ST_DECEL;
                cur_div_d = decel_div(cur_div_d);
                ramp_d    = ramp_dec(ramp_d);
            end

            if (rem_d == '0) begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cur_div_q  <= MAX_C;
            ramp_q     <= '0;
            rem_q      <= '0;
            position_q <= '0;
            dir_q      <= 1'b0;
            half_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_div_q  <= cur_div_d;
            ramp_q     <= ramp_d;
            rem_q      <= rem_d;
            position_q <= position_d;
            dir_q      <= dir_d;
            half_q     <= half_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign cmd_ready = ~busy_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign position  = position_q;

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// Self-checking bench for stepper_move_ctrl: a scoreboard of expected ticks
// (interval, position, coil pattern) is filled as moves are issued.
module tb_stepper_move_ctrl;

    localparam int POS_W = 16;

    typedef struct {
        int          interval;
        logic [15:0] pos;
        logic [3:0]  pat;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [POS_W-1:0] cmd_steps = '0;
    logic             cmd_dir = 1'b0;
    logic             cmd_half = 1'b0;
    logic             abort = 1'b0;
    logic             hold_en = 1'b0;
    logic [3:0]       pulses_out;
    logic             busy;
    logic             done;
    logic [POS_W-1:0] position;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_evt = 0;
    int acc_cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int tick_cnt = 0;
    logic [POS_W-1:0] prev_pos = '0;

    exp_t exp_q[$];
    int   idx_m = 0;
    logic [15:0] pos_m = '0;
    logic [3:0] pat_m [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                              4'b0010, 4'b0011, 4'b0001, 4'b1001};
    int iv10 [10] = '{8, 6, 4, 4, 4, 4, 4, 4, 6, 8};

    stepper_move_ctrl #(
        .POS_W   (POS_W),
        .DIV_W   (8),
        .MAX_DIV (8),
        .MIN_DIV (4),
        .ACC_DEC (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_steps  (cmd_steps),
        .cmd_dir    (cmd_dir),
        .cmd_half   (cmd_half),
        .abort      (abort),
        .hold_en    (hold_en),
        .pulses_out (pulses_out),
        .busy       (busy),
        .done       (done),
        .position   (position)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
        end
    endtask

    // Tick monitor: every position change is a tick and must match the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_pos = position;
        end else begin
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (position !== prev_pos) begin
                tick_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_tick", 32'(position), 32'(prev_pos));
                end else begin
                    e = exp_q.pop_front();
                    if (e.interval != 0) check("tick_interval", cyc - last_evt, e.interval);
                    check("tick_position", 32'(position), 32'(e.pos));
                    check("tick_pattern", 32'(pulses_out), 32'(e.pat));
                end
                last_evt = cyc;
            end
            prev_pos = position;
        end
    end

    task automatic push_tick(input int iv, input bit dir, input bit half, input bit first);
        int   mag;
        exp_t e;
        mag = (half || (first && (idx_m % 2 == 0))) ? 1 : 2;
        if (dir) begin
            idx_m = (idx_m + mag) % 8;
            pos_m = pos_m + 16'(mag);
        end else begin
            idx_m = (idx_m + 8 - mag) % 8;
            pos_m = pos_m - 16'(mag);
        end
        e.interval = iv;
        e.pos      = pos_m;
        e.pat      = pat_m[idx_m];
        exp_q.push_back(e);
    endtask

    task automatic start_move(input int steps, input bit dir, input bit half);
        cmd_steps = POS_W'(steps);
        cmd_dir   = dir;
        cmd_half  = half;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        last_evt  = cyc;
        acc_cyc   = cyc;
    endtask

    task automatic wait_done(input int start, input int budget);
        int n = 0;
        while (done_cnt == start && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("done_within_budget", done_cnt - start, 1);
    endtask

    task automatic wait_ticks(input int left, input int budget);
        int n = 0;
        while (exp_q.size() > left && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("ticks_within_budget", exp_q.size(), left);
    endtask

    task automatic reset_on();
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_off();
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        idx_m = 0;
        pos_m = '0;
    endtask

    initial begin
        int d0;

        // Reset state with hold disabled.
        reset_on();
        check("rst_pulses", 32'(pulses_out), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ready", 32'(cmd_ready), 32'h1);
        check("rst_position", 32'(position), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        reset_off();
        check("idle_pulses", 32'(pulses_out), 32'h0);

        // Forward, half step, 10 steps.
        hold_en = 1'b1;
        for (int i = 0; i < 10; i++) push_tick(iv10[i], 1'b1, 1'b1, i == 0);
        d0 = done_cnt;
        start_move(10, 1'b1, 1'b1);
        check("busy_after_accept", 32'(busy), 32'h1);
        wait_done(d0, 200);
        check("fwd10_queue_drained", exp_q.size(), 0);
        check("fwd10_total_cycles", done_cyc - acc_cyc, 52);
        check("fwd10_position", 32'(position), 32'd10);
        check("fwd10_busy_low", 32'(busy), 32'h0);
        check("fwd10_held_pattern", 32'(pulses_out), 32'b0100);
        hold_en = 1'b0;
        #1;
        check("fwd10_released_pattern", 32'(pulses_out), 32'h0);
        hold_en = 1'b1;
        @(negedge clk);
        #1;
        check("fwd10_single_done", done_cnt - d0, 1);

        // Zero-step move.
        d0 = done_cnt;
        start_move(0, 1'b1, 1'b1);
        check("zero_busy_rise", 32'(busy), 32'h1);
        check("zero_done_not_yet", 32'(done), 32'h0);
        @(posedge clk);
        #1;
        check("zero_done_pulse", 32'(done), 32'h1);
        check("zero_busy_fall", 32'(busy), 32'h0);
        check("zero_pattern", 32'(pulses_out), 32'b0100);
        check("zero_position", 32'(position), 32'd10);
        @(posedge clk);
        #1;
        check("zero_done_one_cycle", 32'(done), 32'h0);

        // Reverse, full step, 3 steps from index 0.
        reset_on();
        reset_off();
        for (int i = 0; i < 3; i++) push_tick(0, 1'b0, 1'b0, i == 0);
        d0 = done_cnt;
        start_move(3, 1'b0, 1'b0);
        wait_done(d0, 100);
        check("rev3_queue_drained", exp_q.size(), 0);
        check("rev3_position", 32'(position), 32'(16'hFFFB));

        // Abort during cruise of a 100-step move.
        reset_on();
        reset_off();
        d0 = done_cnt;
        tick_cnt = 0;
        for (int i = 0; i < 5; i++) push_tick(iv10[i], 1'b1, 1'b1, i == 0);
        start_move(100, 1'b1, 1'b1);
        wait_ticks(0, 100);
        abort = 1'b1;
        push_tick(6, 1'b1, 1'b1, 1'b0);
        push_tick(8, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        abort = 1'b0;
        wait_done(d0, 100);
        check("abort_queue_drained", exp_q.size(), 0);
        check("abort_tick_count", tick_cnt, 7);
        check("abort_position", 32'(position), 32'd7);

        // cmd_valid while busy is ignored.
        d0 = done_cnt;
        for (int i = 0; i < 10; i++) push_tick(iv10[i], 1'b1, 1'b1, i == 0);
        start_move(10, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("ready_while_busy", 32'(cmd_ready), 32'h0);
        cmd_steps = 16'd5;
        cmd_dir   = 1'b0;
        cmd_half  = 1'b0;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_done(d0, 200);
        check("ignore_queue_drained", exp_q.size(), 0);
        check("ignore_position", 32'(position), 32'd17);
        repeat (12) @(posedge clk);
        #1;
        check("ignore_no_new_move", 32'(busy), 32'h0);
        check("ignore_position_stable", 32'(position), 32'd17);

        // Reset mid-move.
        hold_en = 1'b0;
        d0 = done_cnt;
        for (int i = 0; i < 10; i++) push_tick(iv10[i], 1'b1, 1'b1, i == 0);
        start_move(10, 1'b1, 1'b1);
        wait_ticks(7, 100);
        reset_on();
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_ready", 32'(cmd_ready), 32'h1);
        check("midrst_done", 32'(done), 32'h0);
        check("midrst_position", 32'(position), 32'h0);
        check("midrst_pulses", 32'(pulses_out), 32'h0);
        reset_off();
        repeat (30) @(posedge clk);
        #1;
        check("midrst_no_done", done_cnt - d0, 0);
        check("midrst_position_stable", 32'(position), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
